// File: rtl/tour_pkg.sv
// Shared types and constants for the knight-tour command sequencer.
// Command word layout: opcode[15:12], heading[11:4], squares[3:0].
package tour_pkg;

  localparam int unsigned MOVE_W = 8;
  localparam int unsigned CMD_W  = 16;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned HDG_W  = 8;
  localparam int unsigned SQ_W   = 4;
  localparam int unsigned RESP_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LEG1,
    ST_LEG1_WAIT,
    ST_LEG2,
    ST_LEG2_WAIT
  } tour_state_t;

  localparam logic [OP_W-1:0] OP_MOVE     = 4'h2;
  localparam logic [OP_W-1:0] OP_FANFARE  = 4'h3;

  localparam logic [HDG_W-1:0] HEAD_N = 8'h00;
  localparam logic [HDG_W-1:0] HEAD_S = 8'h7F;
  localparam logic [HDG_W-1:0] HEAD_W = 8'h3F;
  localparam logic [HDG_W-1:0] HEAD_E = 8'hBF;

  localparam logic [RESP_W-1:0] RESP_DONE  = 8'hA5;
  localparam logic [RESP_W-1:0] RESP_ACK   = 8'h5A;
  localparam logic [RESP_W-1:0] RESP_ABORT = 8'hAA;

  typedef struct packed {
    logic [HDG_W-1:0] heading;
    logic [SQ_W-1:0]  squares;
  } leg_t;

  typedef struct packed {
    logic [OP_W-1:0]  opcode;
    logic [HDG_W-1:0] heading;
    logic [SQ_W-1:0]  squares;
  } cmd_t;

  function automatic cmd_t build_cmd(input logic [OP_W-1:0] op, input leg_t leg);
    cmd_t c;
    c.opcode  = op;
    c.heading = leg.heading;
    c.squares = leg.squares;
    return c;
  endfunction

endpackage

// File: rtl/tour_cmd_if.sv
// Bundle of move-store, UART and cmd_proc signals around the tour sequencer.
// master = surrounding system, slave = sequencer.
interface tour_cmd_if
  import tour_pkg::*;
#(
  parameter int unsigned NUM_MOVES = 24
) ();

  localparam int unsigned IDX_W = $clog2(NUM_MOVES);

  logic                start_tour;
  logic [MOVE_W-1:0]   move;
  logic [IDX_W-1:0]    mv_indx;
  logic [CMD_W-1:0]    cmd_UART;
  logic                cmd_rdy_UART;
  logic [CMD_W-1:0]    cmd;
  logic                cmd_rdy;
  logic                clr_cmd_rdy;
  logic                send_resp;
  logic [RESP_W-1:0]   resp;
  logic                tour_busy;
  logic                tour_err;

  modport master (
    output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    input  mv_indx, cmd, cmd_rdy, resp, tour_busy, tour_err
  );

  modport slave (
    input  start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    output mv_indx, cmd, cmd_rdy, resp, tour_busy, tour_err
  );

endinterface

// File: rtl/tour_cmd_seq_decode.sv
// Combinational one-hot knight move decode into vertical/horizontal legs.
// Positive dY heads north, positive dX heads east; squares are magnitudes.
module knight_move_decode
  import tour_pkg::*;
(
  input  logic [MOVE_W-1:0] move_i,
  output leg_t              vert_o,
  output leg_t              horz_o,
  output logic              onehot_ok_o
);

  always_comb begin
    vert_o = '{heading: HEAD_N, squares: '0};
    horz_o = '{heading: HEAD_E, squares: '0};
    case (move_i)
      8'h01: begin vert_o = '{HEAD_N, 4'd2}; horz_o = '{HEAD_W, 4'd1}; end
      8'h02: begin vert_o = '{HEAD_N, 4'd2}; horz_o = '{HEAD_E, 4'd1}; end
      8'h04: begin vert_o = '{HEAD_N, 4'd1}; horz_o = '{HEAD_W, 4'd2}; end
      8'h08: begin vert_o = '{HEAD_S, 4'd1}; horz_o = '{HEAD_W, 4'd2}; end
      8'h10: begin vert_o = '{HEAD_S, 4'd2}; horz_o = '{HEAD_W, 4'd1}; end
      8'h20: begin vert_o = '{HEAD_S, 4'd2}; horz_o = '{HEAD_E, 4'd1}; end
      8'h40: begin vert_o = '{HEAD_S, 4'd1}; horz_o = '{HEAD_E, 4'd2}; end
      8'h80: begin vert_o = '{HEAD_N, 4'd1}; horz_o = '{HEAD_E, 4'd2}; end
      default: ;
    endcase
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  always_comb begin
    onehot_ok_o = (move_i != '0) && ((move_i & (move_i - MOVE_W'(1))) == '0);
  end

endmodule

// File: rtl/tour_cmd_seq.sv
// Replays a stored knight tour as pairs of cmd_proc movement commands,
// owning the command path while busy and turning UART commands into aborts.
module tour_cmd_seq
  import tour_pkg::*;
#(
  parameter int unsigned NUM_MOVES  = 24,
  parameter bit          HORZ_FIRST = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  tour_cmd_if.slave bus
);

  localparam int unsigned     IDX_W    = $clog2(NUM_MOVES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

  tour_state_t        state_q, state_d;
  logic [IDX_W-1:0]   mv_indx_q, mv_indx_d;
  logic [MOVE_W-1:0]  mv_q, mv_d;
  logic               abort_pend_q, abort_pend_d;
  logic               tour_err_q, tour_err_d;

  logic [MOVE_W-1:0]  dec_move;
  leg_t               vert_leg, horz_leg;
  logic               onehot_ok;
  cmd_t               vert_cmd, horz_cmd, leg1_cmd, leg2_cmd, seq_cmd;
  logic               seq_rdy;
  logic               busy;
  logic               last_move;

  // One decoder: checks the incoming move during LOAD, otherwise decodes the captured move.
  assign dec_move = (state_q == ST_LOAD) ? bus.move : mv_q;

  knight_move_decode u_decode (
    .move_i      (dec_move),
    .vert_o      (vert_leg),
    .horz_o      (horz_leg),
    .onehot_ok_o (onehot_ok)
  );

  assign vert_cmd  = build_cmd(OP_MOVE, vert_leg);
  assign horz_cmd  = build_cmd(OP_FANFARE, horz_leg);
  assign leg1_cmd  = HORZ_FIRST ? horz_cmd : vert_cmd;
  assign leg2_cmd  = HORZ_FIRST ? vert_cmd : horz_cmd;
  assign busy      = (state_q != ST_IDLE);
  assign last_move = (mv_indx_q == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mv_indx_q    <= '0;
      mv_q         <= '0;
      abort_pend_q <= 1'b0;
      tour_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mv_indx_q    <= mv_indx_d;
      mv_q         <= mv_d;
      abort_pend_q <= abort_pend_d;
      tour_err_q   <= tour_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mv_indx_d    = mv_indx_q;
    mv_d         = mv_q;
    abort_pend_d = abort_pend_q;
    tour_err_d   = tour_err_q;
    seq_rdy      = 1'b0;

    // A UART command while busy is swallowed and latched as an abort request.
    if (busy && bus.cmd_rdy_UART) begin
      abort_pend_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_tour) begin
          state_d      = ST_LOAD;
          mv_indx_d    = '0;
          tour_err_d   = 1'b0;
          abort_pend_d = 1'b0;
        end
      end
      ST_LOAD: begin
        mv_d = bus.move;
        if (!onehot_ok) begin
          tour_err_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_LEG1;
        end
      end
      ST_LEG1: begin
        seq_rdy = 1'b1;
        if (bus.clr_cmd_rdy) state_d = ST_LEG1_WAIT;
      end
      ST_LEG1_WAIT: begin
        if (bus.send_resp) state_d = abort_pend_q ? ST_IDLE : ST_LEG2;
      end
      ST_LEG2: begin
        seq_rdy = 1'b1;
        if (bus.clr_cmd_rdy) state_d = ST_LEG2_WAIT;
      end
      ST_LEG2_WAIT: begin
        if (bus.send_resp) begin
          if (abort_pend_q || last_move) begin
            state_d = ST_IDLE;
          end else begin
            mv_indx_d = mv_indx_q + IDX_W'(1);
            state_d   = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    seq_cmd = leg1_cmd;
    if ((state_q == ST_LEG2) || (state_q == ST_LEG2_WAIT)) seq_cmd = leg2_cmd;
  end

  always_comb begin
    bus.resp = RESP_ACK;
    if (!busy)                                    bus.resp = RESP_DONE;
    else if (abort_pend_q)                        bus.resp = RESP_ABORT;
    else if ((state_q == ST_LEG2_WAIT) && last_move) bus.resp = RESP_DONE;
  end

  assign bus.cmd       = busy ? seq_cmd : bus.cmd_UART;
  assign bus.cmd_rdy   = busy ? seq_rdy : bus.cmd_rdy_UART;
  assign bus.tour_busy = busy;
  assign bus.tour_err  = tour_err_q;
  assign bus.mv_indx   = mv_indx_q;

endmodule

// File: doc/tour_cmd_seq.md
# tour_cmd_seq

Parametrised tour command sequencer between the tour solver (move store) and `cmd_proc`. On `start_tour` it replays a stored sequence of one-hot knight moves as pairs of `cmd_proc` movement commands (two legs per move), muxing them over the UART command path while busy. Adds over the previous generation: configurable tour length, selectable leg order, registered move capture with one-hot checking, and UART-initiated abort.

## Interface
- `NUM_MOVES`, 24: moves per tour (2..256); `IDX_W = $clog2(NUM_MOVES)` is a derived localparam.
- `HORZ_FIRST`, 0: 0 = vertical leg then horizontal leg; 1 = horizontal then vertical.
- `clk`  in  1  single system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start_tour`  in  1  pulse from tour solver done.
- `move`  in  8  one-hot move addressed by `mv_indx`, combinationally valid the same cycle.
- `mv_indx`  out  IDX_W  move address.
- `cmd_UART`  in  16  command from UART wrapper.
- `cmd_rdy_UART`  in  1  UART command ready.
- `cmd`  out  16  muxed command to `cmd_proc`.
- `cmd_rdy`  out  1  muxed command ready.
- `clr_cmd_rdy`  in  1  `cmd_proc` accepted command.
- `send_resp`  in  1  `cmd_proc` finished command.
- `resp`  out  8  response byte.
- `tour_busy`  out  1  sequencer owns command path.
- `tour_err`  out  1  sticky: non-one-hot move seen.

## Operation
- Command format: `[15:12]` opcode (4'h2 move, 4'h3 move with fanfare); `[11:4]` heading (8'h00 N, 8'h7F S, 8'h3F W, 8'hBF E); `[3:0]` squares.
- Move decode (bit: dY,dX): 0: +2,-1; 1: +2,+1; 2: +1,-2; 3: -1,-2; 4: -2,-1; 5: -2,+1; 6: -1,+2; 7: +1,+2.
- Vertical leg always opcode 4'h2; horizontal leg always 4'h3, regardless of order. Legs are emitted in the order set by `HORZ_FIRST`.
- States: IDLE, LOAD, LEG1, LEG1_WAIT, LEG2, LEG2_WAIT.
- IDLE: `start_tour` -> LOAD; clears `mv_indx`, `tour_err`, and `abort_pend`.
- LOAD: registers `move` into `mv_reg`.
  - Not exactly one bit set -> set `tour_err`, go to IDLE.
  - Otherwise go to LEG1.
- LEG1/LEG2: `cmd_rdy`=1; `cmd` built from `mv_reg`. On `clr_cmd_rdy` go to the matching _WAIT state.
- LEG1_WAIT: on `send_resp` go to LEG2, or to IDLE if `abort_pend`.
- LEG2_WAIT: on `send_resp`:
  - `abort_pend` -> IDLE.
  - `mv_indx == NUM_MOVES-1` -> IDLE.
  - Otherwise `mv_indx`+1 and go to LOAD.
- `tour_busy` = state != IDLE. While busy, `cmd`/`cmd_rdy` come from the sequencer; otherwise `cmd_UART`/`cmd_rdy_UART` pass through.
- Abort: `cmd_rdy_UART`=1 while busy sets `abort_pend`. The UART command is dropped and never forwarded. Abort takes effect at the next leg completion; the leg in flight is never cut.
- `resp` priority:
  - !busy -> 8'hA5
  - `abort_pend` -> 8'hAA
  - LEG2_WAIT with `mv_indx == NUM_MOVES-1` -> 8'hA5
  - else 8'h5A

## Timing
- Reset values: state IDLE, `mv_indx` 0, `mv_reg` 0, `abort_pend` 0, `tour_err` 0, `tour_busy` 0, `cmd_rdy` = `cmd_rdy_UART`, `resp` 8'hA5.
- `start_tour` at edge N: LOAD in cycle N+1; `cmd_rdy` high in cycle N+2.
- `send_resp` in LEG2_WAIT: `mv_indx` increments at the same edge. The next `cmd_rdy` follows 2 cycles later (LOAD, then LEG1).
- `start_tour` outside IDLE is ignored.
- `clr_cmd_rdy` and `send_resp` in the same cycle in LEGn: only `clr_cmd_rdy` acts; `send_resp` is ignored.
- `rst` mid-tour: immediate return to reset values; the UART path is restored combinationally.
- `resp` is combinational and valid in the cycle `send_resp` is high.

## Structure
- Package `tour_pkg`: state enum `tour_state_t`, opcode constants, heading constants, response constants (A5/5A/AA).
- Sub-module `knight_move_decode`: combinational move -> {vert heading, vert squares, horz heading, horz squares, onehot_ok}.

## Test plan
- `NUM_MOVES`=24, `HORZ_FIRST`=0, all moves 8'h02 -> 48 commands alternating 16'h2002 / 16'h3BF1; `resp` 5A on the first 47 and A5 on the 48th; return to IDLE with `mv_indx`=23.
- `HORZ_FIRST`=1, move 8'h08 -> first `cmd` 16'h33F2, then 16'h27F1.
- `move`=8'h06 at index 3 -> `tour_err`=1 after the LOAD cycle; IDLE; no `cmd_rdy` issued.
- `cmd_rdy_UART` pulse during LEG1_WAIT of move 5 -> the UART command is not forwarded; `send_resp` returns `resp` 8'hAA; IDLE; `tour_busy`=0.
- `NUM_MOVES`=4: 8 legs, then IDLE. Assert `rst` during LEG2 of move 1 -> `cmd` = `cmd_UART` immediately and `mv_indx`=0.
- Idle passthrough: `cmd_UART`=16'h4000, `cmd_rdy_UART`=1 -> `cmd`=16'h4000, `cmd_rdy`=1, `resp`=8'hA5.
